// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma rotor datapath.
package enigma_pkg;

  // Letters per rotor ring (A..Z).
  localparam int unsigned ALPHA = 26;

  // Default turnover notches: rot1 leaves Q, rot2 leaves E.
  localparam int unsigned NOTCH1_DEF = 16;
  localparam int unsigned NOTCH2_DEF = 4;

  // Stepper FSM encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStep   = 2'd1,
    StStrobe = 2'd2
  } step_state_e;

  // True when a 5-bit position is a legal ring letter.
  function automatic logic pos_legal(input logic [4:0] pos);
    return pos < 5'(ALPHA);
  endfunction

endpackage

// File: rtl/rotor_pos_inc.sv
// Mod-26 position incrementer with a compare against a fixed notch position.
module rotor_pos_inc
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH = 0
) (
  input  logic [4:0] pos,
  output logic [4:0] pos_next,
  output logic       at_notch
);

  // Wrap Z back to A; inputs are always kept in 0..25 by the caller.
  always_comb begin
    pos_next = (pos == 5'(ALPHA - 1)) ? 5'd0 : pos + 5'd1;
    at_notch = (pos == 5'(NOTCH));
  end

endmodule

// File: rtl/rotor_stepper.sv
// Rotor position controller: holds the three rotor offsets and the keypress counter,
// advancing them once per accepted keypress with notch turnover and double-stepping.
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH1 = NOTCH1_DEF,
  parameter int unsigned NOTCH2 = NOTCH2_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] init1,
  input  logic [4:0] init2,
  input  logic [4:0] init3,
  input  logic       key_valid,
  output logic [4:0] rot1,
  output logic [4:0] rot2,
  output logic [4:0] rot3,
  output logic [5:0] counter,
  output logic       busy,
  output logic       pos_valid,
  output logic       load_err
);

  step_state_e state_q, state_d;
  logic [4:0]  rot1_q, rot1_d;
  logic [4:0]  rot2_q, rot2_d;
  logic [4:0]  rot3_q, rot3_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pos_valid_q, pos_valid_d;
  logic        load_err_q, load_err_d;

  logic [4:0]  rot1_inc, rot2_inc, rot3_inc, cnt_inc;
  logic        rot1_notch, rot2_notch;
  logic        unused_rot3_notch, unused_cnt_notch;
  logic        load_ok;
  logic        turn2;

  rotor_pos_inc #(.NOTCH(NOTCH1)) u_inc1 (
    .pos      (rot1_q),
    .pos_next (rot1_inc),
    .at_notch (rot1_notch)
  );

  rotor_pos_inc #(.NOTCH(NOTCH2)) u_inc2 (
    .pos      (rot2_q),
    .pos_next (rot2_inc),
    .at_notch (rot2_notch)
  );

  rotor_pos_inc #(.NOTCH(0)) u_inc3 (
    .pos      (rot3_q),
    .pos_next (rot3_inc),
    .at_notch (unused_rot3_notch)
  );

  rotor_pos_inc #(.NOTCH(0)) u_inc_cnt (
    .pos      (cnt_q),
    .pos_next (cnt_inc),
    .at_notch (unused_cnt_notch)
  );

  // Load is rejected as a whole if any ring value is out of range.
  always_comb begin
    load_ok = pos_legal(init1) && pos_legal(init2) && pos_legal(init3);
    // rot2 at its own notch drags itself along with rot3 (double step).
    turn2   = rot1_notch || rot2_notch;
  end

  // Next-state logic: a keypress is only taken in idle and only when no load competes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (key_valid && !load) state_d = StStep;
      StStep:   state_d = StStrobe;
      StStrobe: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next values: load in idle, or one step when leaving StStep.
  always_comb begin
    rot1_d      = rot1_q;
    rot2_d      = rot2_q;
    rot3_d      = rot3_q;
    cnt_d       = cnt_q;
    pos_valid_d = 1'b0;
    load_err_d  = 1'b0;
    if (state_q == StIdle && load) begin
      if (load_ok) begin
        rot1_d      = init1;
        rot2_d      = init2;
        rot3_d      = init3;
        cnt_d       = 5'd0;
        pos_valid_d = 1'b1;
      end else begin
        load_err_d  = 1'b1;
      end
    end else if (state_q == StStep) begin
      rot1_d      = rot1_inc;
      rot2_d      = turn2 ? rot2_inc : rot2_q;
      rot3_d      = rot2_notch ? rot3_inc : rot3_q;
      cnt_d       = cnt_inc;
      pos_valid_d = 1'b1;
    end
  end

  // State and output registers; reset aborts any step in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rot1_q      <= 5'd0;
      rot2_q      <= 5'd0;
      rot3_q      <= 5'd0;
      cnt_q       <= 5'd0;
      pos_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot1_q      <= rot1_d;
      rot2_q      <= rot2_d;
      rot3_q      <= rot3_d;
      cnt_q       <= cnt_d;
      pos_valid_q <= pos_valid_d;
      load_err_q  <= load_err_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    rot1      = rot1_q;
    rot2      = rot2_q;
    rot3      = rot3_q;
    counter   = {1'b0, cnt_q};
    busy      = (state_q != StIdle);
    pos_valid = pos_valid_q;
    load_err  = load_err_q;
  end

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed vector table, hand-written corner
// sequences and random operations compared against an arithmetic reference model.
module tb_rotor_stepper;

  localparam int NOTCH1 = 16;
  localparam int NOTCH2 = 4;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] init1, init2, init3;
  logic       key_valid;
  logic [4:0] rot1, rot2, rot3;
  logic [5:0] counter;
  logic       busy, pos_valid, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m1, m2, m3, mcnt;

  rotor_stepper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .init1     (init1),
    .init2     (init2),
    .init3     (init3),
    .key_valid (key_valid),
    .rot1      (rot1),
    .rot2      (rot2),
    .rot3      (rot3),
    .counter   (counter),
    .busy      (busy),
    .pos_valid (pos_valid),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    bit m, t;
    m    = (m2 == NOTCH2);
    t    = (m1 == NOTCH1) || m;
    m1   = (m1 + 1) % 26;
    if (t) m2 = (m2 + 1) % 26;
    if (m) m3 = (m3 + 1) % 26;
    mcnt = (mcnt + 1) % 26;
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".rot1"}, int'(rot1), m1);
    check({tag, ".rot2"}, int'(rot2), m2);
    check({tag, ".rot3"}, int'(rot3), m3);
    check({tag, ".counter"}, int'(counter), mcnt);
  endtask

  // One full keypress: E0 accept, E1 update with strobe, E2 back to idle.
  task automatic do_key();
    int p1;
    p1 = m1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("key.e0.busy", int'(busy), 1);
    check("key.e0.pos_valid", int'(pos_valid), 0);
    check("key.e0.rot1_held", int'(rot1), p1);
    model_step();
    tick();
    check("key.e1.pos_valid", int'(pos_valid), 1);
    check("key.e1.busy", int'(busy), 1);
    check_pos("key.e1");
    tick();
    check("key.e2.pos_valid", int'(pos_valid), 0);
    check("key.e2.busy", int'(busy), 0);
  endtask

  task automatic do_load(input int a, input int b, input int c);
    bit ok;
    ok    = (a <= 25) && (b <= 25) && (c <= 25);
    load  = 1'b1;
    init1 = 5'(a);
    init2 = 5'(b);
    init3 = 5'(c);
    tick();
    load = 1'b0;
    check("load.pos_valid", int'(pos_valid), int'(ok));
    check("load.load_err", int'(load_err), int'(!ok));
    check("load.busy", int'(busy), 0);
    if (ok) begin
      m1 = a; m2 = b; m3 = c; mcnt = 0;
    end
    check_pos("load");
    tick();
    check("load.pulse_end", int'(pos_valid | load_err), 0);
  endtask

  typedef struct {
    bit is_load;
    int i1, i2, i3;
    int e1, e2, e3, ecnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int pulses;
    int r1_before;
    rst_n = 1'b0; load = 1'b0; key_valid = 1'b0;
    init1 = '0; init2 = '0; init3 = '0;
    m1 = 0; m2 = 0; m3 = 0; mcnt = 0;

    vecs[0] = '{0,  0,  0,  0,  1,  0,  0, 1};
    vecs[1] = '{1, 16,  3,  0, 16,  3,  0, 0};
    vecs[2] = '{0,  0,  0,  0, 17,  4,  0, 1};
    vecs[3] = '{0,  0,  0,  0, 18,  5,  1, 2};
    vecs[4] = '{1, 25, 25, 25, 25, 25, 25, 0};
    vecs[5] = '{0,  0,  0,  0,  0, 25, 25, 1};
    vecs[6] = '{1, 30,  0,  0,  0, 25, 25, 1};
    vecs[7] = '{1, 15,  4, 25, 15,  4, 25, 0};
    vecs[8] = '{0,  0,  0,  0, 16,  5,  0, 1};
    vecs[9] = '{0,  0,  0,  0, 17,  6,  0, 2};

    // Reset values.
    #2;
    check("reset.rot1", int'(rot1), 0);
    check("reset.rot2", int'(rot2), 0);
    check("reset.rot3", int'(rot3), 0);
    check("reset.counter", int'(counter), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.pos_valid", int'(pos_valid), 0);
    check("reset.load_err", int'(load_err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_load) do_load(vecs[i].i1, vecs[i].i2, vecs[i].i3);
      else do_key();
      check($sformatf("vec%0d.rot1", i), int'(rot1), vecs[i].e1);
      check($sformatf("vec%0d.rot2", i), int'(rot2), vecs[i].e2);
      check($sformatf("vec%0d.rot3", i), int'(rot3), vecs[i].e3);
      check($sformatf("vec%0d.counter", i), int'(counter), vecs[i].ecnt);
    end

    // Counter wraps after 26 keys from zero.
    do_load(0, 0, 0);
    for (int i = 0; i < 26; i++) do_key();
    check("wrap26.counter", int'(counter), 0);

    // key_valid held for 9 cycles: one step every 3 cycles.
    r1_before = m1;
    pulses = 0;
    key_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (pos_valid) pulses++;
    end
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) model_step();
    check("held.pulses", pulses, 3);
    check("held.rot1", int'(rot1), (r1_before + 3) % 26);
    check("held.busy", int'(busy), 0);
    check_pos("held");

    // Load together with key_valid: load wins, no step.
    load = 1'b1; key_valid = 1'b1;
    init1 = 5'd5; init2 = 5'd6; init3 = 5'd7;
    tick();
    load = 1'b0; key_valid = 1'b0;
    m1 = 5; m2 = 6; m3 = 7; mcnt = 0;
    check("both.busy", int'(busy), 0);
    check("both.pos_valid", int'(pos_valid), 1);
    check_pos("both");
    tick(); tick();
    check("both.no_step", int'(pos_valid | busy), 0);
    check_pos("both.after");

    // Load while busy is ignored.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    load = 1'b1; init1 = 5'd1; init2 = 5'd1; init3 = 5'd1;
    model_step();
    tick();
    load = 1'b0;
    check("busyload.load_err", int'(load_err), 0);
    check_pos("busyload");
    tick();
    tick();
    check_pos("busyload.after");

    // Reset during STROBE: outputs clear at once, no strobe afterwards.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    check("rststrobe.pre_pos_valid", int'(pos_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rststrobe.rot1", int'(rot1), 0);
    check("rststrobe.rot2", int'(rot2), 0);
    check("rststrobe.rot3", int'(rot3), 0);
    check("rststrobe.counter", int'(counter), 0);
    check("rststrobe.busy", int'(busy), 0);
    check("rststrobe.pos_valid", int'(pos_valid), 0);
    m1 = 0; m2 = 0; m3 = 0; mcnt = 0;
    tick();
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pos_valid || busy) pulses++;
    end
    check("rststrobe.quiet", pulses, 0);
    check_pos("rststrobe.after");

    // Random operations against the model.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 7) do_key();
      else if (op < 9) do_load(int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                               int'($urandom_range(0, 25)));
      else do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
